// File: rtl/dmem_resp_if.sv
// rtl/dmem_resp_if.sv - load/store request and response bundle between pipeline and dmem_resp
interface dmem_resp_if;
  logic        req_val;
  logic        req_rdy;
  logic        req_wr;
  logic        req_byte;
  logic [31:0] req_addr;
  logic [31:0] req_wdat;
  logic        rsp_val;
  logic [31:0] rsp_rdat;
  logic        rsp_err;

  modport master (
    output req_val, req_wr, req_byte, req_addr, req_wdat,
    input  req_rdy, rsp_val, rsp_rdat, rsp_err
  );

  modport slave (
    input  req_val, req_wr, req_byte, req_addr, req_wdat,
    output req_rdy, rsp_val, rsp_rdat, rsp_err
  );
endinterface

// File: rtl/dmem_resp.sv
// rtl/dmem_resp.sv - byte-lane data-memory responder, big-endian, optional split of misaligned words (DMEM_RESP_SPLIT_EN)
module dmem_resp #(
  parameter int ADDR_W = 8
) (
  input  logic       clk,
  input  logic       reset,
  dmem_resp_if.slave bus
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic {IDLE, SECOND} state_t;

  state_t state_q, state_d;

  // Word storage; lane k of a word lives in bits [31-8k -: 8]. Not reset.
  logic [31:0] mem [DEPTH];

  logic [1:0]       off;
  logic [IDX_W-1:0] idx_a;
  logic [31:0]      rd_a;
  logic [7:0]       rd_byte;
  logic             unused_addr;

  assign off         = bus.req_addr[1:0];
  assign idx_a       = bus.req_addr[ADDR_W-1:2];
  assign rd_a        = mem[idx_a];
  assign rd_byte     = 8'(rd_a >> {~off, 3'b000});
  assign unused_addr = ^bus.req_addr[31:ADDR_W];

  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [3:0]       wr_be;
  logic [31:0]      wr_data;

  logic        rsp_val_q, rsp_val_d;
  logic [31:0] rsp_rdat_q, rsp_rdat_d;
  logic        rsp_err_q, rsp_err_d;

`ifdef DMEM_RESP_SPLIT_EN
  // Fields of a misaligned word request carried into the second RAM cycle.
  logic [1:0]       off_q;
  logic             wr_q;
  logic [IDX_W-1:0] idx_b_q;
  logic [31:0]      wdat_q;
  logic [31:0]      hold_q;
  logic             cap;
  logic [31:0]      rd_b;
  logic [5:0]       sh_lo;
  logic [5:0]       sh_hi;

  assign rd_b  = mem[idx_b_q];
  assign sh_lo = {1'b0, off_q, 3'b000};
  assign sh_hi = 6'd32 - sh_lo;
`endif

  assign bus.req_rdy  = (state_q == IDLE);
  assign bus.rsp_val  = rsp_val_q;
  assign bus.rsp_rdat = rsp_rdat_q;
  assign bus.rsp_err  = rsp_err_q;

  // Next state, RAM write port and response for the current cycle.
  always_comb begin
    state_d    = state_q;
    wr_en      = 1'b0;
    wr_idx     = idx_a;
    wr_be      = 4'b0000;
    wr_data    = 32'h0;
    rsp_val_d  = 1'b0;
    rsp_rdat_d = 32'h0;
    rsp_err_d  = 1'b0;
`ifdef DMEM_RESP_SPLIT_EN
    cap        = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (bus.req_val) begin
          if (bus.req_byte) begin
            rsp_val_d = 1'b1;
            wr_en     = bus.req_wr;
            wr_be     = 4'b0001 << off;
            wr_data   = {4{bus.req_wdat[7:0]}};
            if (!bus.req_wr) rsp_rdat_d = {24'h0, rd_byte};
          end
`ifdef DMEM_RESP_SPLIT_EN
          else if (off != 2'd0) begin
            // First half: leading bytes of the store land in lanes off..3 of word A.
            wr_en   = bus.req_wr;
            wr_be   = 4'b1111 << off;
            wr_data = bus.req_wdat >> {off, 3'b000};
            cap     = 1'b1;
            state_d = SECOND;
          end
`endif
          else begin
            rsp_val_d = 1'b1;
            wr_en     = bus.req_wr;
            wr_be     = 4'b1111;
            wr_data   = bus.req_wdat;
            if (!bus.req_wr) rsp_rdat_d = rd_a;
`ifndef DMEM_RESP_SPLIT_EN
            rsp_err_d = (off != 2'd0);
`endif
          end
        end
      end
`ifdef DMEM_RESP_SPLIT_EN
      SECOND: begin
        // Second half: trailing bytes go to lanes 0..off-1 of word B.
        wr_en     = wr_q;
        wr_idx    = idx_b_q;
        wr_be     = ~(4'b1111 << off_q);
        wr_data   = wdat_q << sh_hi;
        rsp_val_d = 1'b1;
        if (!wr_q) rsp_rdat_d = (hold_q << sh_lo) | (rd_b >> sh_hi);
        state_d   = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Byte-enabled RAM write; suppressed while reset is high.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      for (int k = 0; k < 4; k++) begin
        if (wr_be[k]) mem[wr_idx][31-8*k -: 8] <= wr_data[31-8*k -: 8];
      end
    end
  end

  // State and registered response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rsp_val_q  <= 1'b0;
      rsp_rdat_q <= 32'h0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rsp_val_q  <= rsp_val_d;
      rsp_rdat_q <= rsp_rdat_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

`ifdef DMEM_RESP_SPLIT_EN
  // Capture request fields and word A when a split starts.
  always_ff @(posedge clk) begin
    if (reset) begin
      off_q   <= 2'd0;
      wr_q    <= 1'b0;
      idx_b_q <= '0;
      wdat_q  <= 32'h0;
      hold_q  <= 32'h0;
    end else if (cap) begin
      off_q   <= off;
      wr_q    <= bus.req_wr;
      idx_b_q <= idx_a + 1'b1;
      wdat_q  <= bus.req_wdat;
      hold_q  <= rd_a;
    end
  end
`endif

endmodule
